// File: rtl/signdiv_param.sv
// signdiv_param: sequential restoring divider, 2W-bit dividend by W-bit divisor.
// Signed or unsigned operation is chosen per operation. The unit works on operand
// magnitudes and applies the result signs in a final fix-up step. Divide-by-zero
// and quotient overflow are reported as flags alongside done.
module signdiv_param #(
    parameter int W = 16
) (
    input  logic           CLK,
    input  logic           RSTn,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero,
    output logic           ovf
);

    // The counter must hold W-1, which is the index of the last iteration.
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
    // 2^(W-1): the largest quotient magnitude allowed for a negative result.
    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        DIVIDE = 2'd2,
        FIX    = 2'd3
    } state_t;

    state_t        state_reg;
    logic          mode_reg;
    logic          sign_dvd_reg;   // dividend was negative (signed mode only)
    logic          sign_dvs_reg;   // divisor was negative (signed mode only)
    logic [W-1:0]  rem_reg;        // partial remainder; holds |dividend| high half before DIVIDE
    logic [W-1:0]  quo_reg;        // quotient shift register; holds |dividend| low half before DIVIDE
    logic [W-1:0]  dvs_reg;        // |divisor|
    logic [CW-1:0] cnt_reg;

    logic          busy_reg;
    logic          done_reg;
    logic [W-1:0]  quotient_reg;
    logic [W-1:0]  remainder_reg;
    logic          div_zero_reg;
    logic          ovf_reg;

    // Operand magnitudes at the accepting edge. In unsigned mode they equal the raw inputs.
    logic           dvd_neg_next;
    logic           dvs_neg_next;
    logic [2*W-1:0] dvd_mag_next;
    logic [W-1:0]   dvs_mag_next;

    always_comb begin
        dvd_neg_next = signed_mode & dividend[2*W-1];
        dvs_neg_next = signed_mode & divisor[W-1];
        dvd_mag_next = dvd_neg_next ? -dividend : dividend;
        dvs_mag_next = dvs_neg_next ? -divisor : divisor;
    end

    // One restoring step. The partial remainder is always below |divisor|, so the
    // shifted value is below 2*|divisor|. Bit W of the difference is therefore a
    // clean borrow flag: when it is clear, the subtraction is kept.
    logic [W:0]   shift_rem;
    logic [W:0]   diff;
    logic         fits;
    logic [W-1:0] rem_step;
    logic [W-1:0] quo_step;

    always_comb begin
        shift_rem = {rem_reg, quo_reg[W-1]};
        diff      = shift_rem - {1'b0, dvs_reg};
        fits      = ~diff[W];
        rem_step  = fits ? diff[W-1:0] : shift_rem[W-1:0];
        quo_step  = {quo_reg[W-2:0], fits};
    end

    // Pre-checks on the stored magnitudes. When the high half of the dividend is
    // at least the divisor, the quotient cannot fit in W bits.
    logic dvs_zero;
    logic hi_ovf;

    always_comb begin
        dvs_zero = (dvs_reg == '0);
        hi_ovf   = (rem_reg >= dvs_reg);
    end

    // Sign fix-up and signed range check on the unsigned quotient magnitude.
    logic         q_neg;
    logic         r_neg;
    logic [W-1:0] q_fix;
    logic [W-1:0] r_fix;
    logic         range_fail;

    always_comb begin
        q_neg      = sign_dvd_reg ^ sign_dvs_reg;
        r_neg      = sign_dvd_reg;
        q_fix      = q_neg ? -quo_reg : quo_reg;
        r_fix      = r_neg ? -rem_reg : rem_reg;
        range_fail = mode_reg & (q_neg ? (quo_reg > HALF) : (quo_reg >= HALF));
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg     <= IDLE;
            mode_reg      <= 1'b0;
            sign_dvd_reg  <= 1'b0;
            sign_dvs_reg  <= 1'b0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg     <= signed_mode;
                        sign_dvd_reg <= dvd_neg_next;
                        sign_dvs_reg <= dvs_neg_next;
                        rem_reg      <= dvd_mag_next[2*W-1:W];
                        quo_reg      <= dvd_mag_next[W-1:0];
                        dvs_reg      <= dvs_mag_next;
                        div_zero_reg <= 1'b0;
                        ovf_reg      <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= CHECK;
                    end
                end

                CHECK: begin
                    if (dvs_zero) begin
                        div_zero_reg  <= 1'b1;
                        ovf_reg       <= 1'b0;
                        quotient_reg  <= '0;
                        remainder_reg <= '0;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (hi_ovf) begin
                        div_zero_reg  <= 1'b0;
                        ovf_reg       <= 1'b1;
                        quotient_reg  <= '0;
                        remainder_reg <= '0;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end else begin
                        cnt_reg   <= '0;
                        state_reg <= DIVIDE;
                    end
                end

                DIVIDE: begin
                    rem_reg <= rem_step;
                    quo_reg <= quo_step;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= FIX;
                    end
                end

                FIX: begin
                    if (range_fail) begin
                        ovf_reg       <= 1'b1;
                        quotient_reg  <= '0;
                        remainder_reg <= '0;
                    end else begin
                        ovf_reg       <= 1'b0;
                        quotient_reg  <= q_fix;
                        remainder_reg <= r_fix;
                    end
                    div_zero_reg <= 1'b0;
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign div_zero  = div_zero_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_signdiv_param.sv
// tb_signdiv_param: scenario tasks for the W=16 divider. Expected results are
// queued when an operation is issued and popped when done is observed.
module tb_signdiv_param;

    localparam int W = 16;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          start = 1'b0;
    logic          signed_mode = 1'b0;
    logic [31:0]   dividend = '0;
    logic [15:0]   divisor = '0;
    logic          busy;
    logic          done;
    logic [15:0]   quotient;
    logic [15:0]   remainder;
    logic          div_zero;
    logic          ovf;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int unsigned lat;
        int unsigned bsy;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    signdiv_param #(.W(W)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_zero    (div_zero),
        .ovf         (ovf)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model built on the division operator over magnitudes.
    function automatic res_t model(input logic [31:0] dvd, input logic [15:0] dvs, input logic sm);
        res_t        e;
        logic [31:0] dm;
        logic [15:0] vm;
        logic [31:0] qm;
        logic [31:0] rm;
        logic        nq;
        logic        nr;
        e  = '0;
        nr = sm & dvd[31];
        nq = sm & (dvd[31] ^ dvs[15]);
        dm = nr ? -dvd : dvd;
        vm = (sm & dvs[15]) ? -dvs : dvs;
        if (vm == 16'd0) begin
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            qm = dm / {16'd0, vm};
            rm = dm % {16'd0, vm};
            if (qm > 32'h0000_FFFF) begin
                e.ov  = 1'b1;
                e.lat = 2;
            end else if (sm && (nq ? (qm > 32'h8000) : (qm > 32'h7FFF))) begin
                e.ov  = 1'b1;
                e.lat = 19;
            end else begin
                e.q   = nq ? -qm[15:0] : qm[15:0];
                e.r   = nr ? -rm[15:0] : rm[15:0];
                e.lat = 19;
            end
        end
        e.bsy = e.lat - 1;
        return e;
    endfunction

    // Drive one start request; the caller is positioned away from a rising edge.
    task automatic issue(input logic [31:0] dvd, input logic [15:0] dvs, input logic sm, input res_t e);
        dividend    = dvd;
        divisor     = dvs;
        signed_mode = sm;
        start       = 1'b1;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; returns observed outputs, latency and busy cycle count.
    task automatic collect(input int lat0, input int bsy0, output res_t o, output bit timeout);
        int lat;
        int bsy;
        lat     = lat0;
        bsy     = bsy0;
        timeout = 1'b1;
        o       = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (done === 1'b1) begin
                o.q     = quotient;
                o.r     = remainder;
                o.dz    = div_zero;
                o.ov    = ovf;
                o.lat   = lat;
                o.bsy   = bsy;
                timeout = 1'b0;
                break;
            end
            if (busy === 1'b1) bsy++;
            @(posedge CLK);
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({busy, done, quotient, remainder, div_zero, ovf} !== 35'd0) begin
            n_errors++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b ovf=%b, expected all 0",
                     busy, done, quotient, remainder, div_zero, ovf);
        end else begin
            $display("txn reset_state: outputs all 0");
        end
        RSTn = 1'b1;
    endtask

    task automatic test_unsigned();
        res_t got;
        res_t e;
        bit   to;
        @(negedge CLK);
        issue(32'd1000, 16'd7, 1'b0, '{16'd142, 16'd6, 1'b0, 1'b0, 19, 18});
        collect(1, 0, got, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || got !== e) begin
            n_errors++;
            $display("FAIL unsigned_1000_7: got q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d to=%b, expected q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d",
                     got.q, got.r, got.dz, got.ov, got.lat, got.bsy, to, e.q, e.r, e.dz, e.ov, e.lat, e.bsy);
        end else begin
            $display("txn unsigned 1000/7: q=%h r=%h lat=%0d", got.q, got.r, got.lat);
        end
        @(negedge CLK);
        n_checks++;
        if (done !== 1'b0 || quotient !== 16'd142) begin
            n_errors++;
            $display("FAIL done_pulse_hold: got done=%b q=%h, expected done=0 q=008e", done, quotient);
        end else begin
            $display("txn done_pulse_hold: done low, quotient held");
        end
    endtask

    task automatic test_signed();
        logic [31:0] dv[3];
        logic [15:0] ds[3];
        res_t        ex[3];
        res_t        got;
        res_t        e;
        bit          to;
        dv = '{32'hFFFF_FC18, 32'd1000, 32'hFFFF_FC18};
        ds = '{16'd7, 16'hFFF9, 16'hFFF9};
        ex = '{'{16'hFF72, 16'hFFFA, 1'b0, 1'b0, 19, 18},
               '{16'hFF72, 16'h0006, 1'b0, 1'b0, 19, 18},
               '{16'h008E, 16'hFFFA, 1'b0, 1'b0, 19, 18}};
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            issue(dv[i], ds[i], 1'b1, ex[i]);
            collect(1, 0, got, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || got !== e) begin
                n_errors++;
                $display("FAIL signed_%0d: got q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d to=%b, expected q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d",
                         i, got.q, got.r, got.dz, got.ov, got.lat, got.bsy, to, e.q, e.r, e.dz, e.ov, e.lat, e.bsy);
            end else begin
                $display("txn signed %h/%h: q=%h r=%h lat=%0d", dv[i], ds[i], got.q, got.r, got.lat);
            end
        end
    endtask

    task automatic test_div_zero();
        res_t got;
        res_t e;
        bit   to;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            issue((i == 0) ? 32'd1234 : 32'hFFFF_FC18, 16'd0, i[0], '{16'd0, 16'd0, 1'b1, 1'b0, 2, 1});
            collect(1, 0, got, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || got !== e) begin
                n_errors++;
                $display("FAIL div_zero_%0d: got q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d to=%b, expected q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d",
                         i, got.q, got.r, got.dz, got.ov, got.lat, got.bsy, to, e.q, e.r, e.dz, e.ov, e.lat, e.bsy);
            end else begin
                $display("txn div_zero mode=%0d: dz=%b lat=%0d", i, got.dz, got.lat);
            end
        end
        // Next accept clears the flag while results stay held until done.
        @(negedge CLK);
        issue(32'd100, 16'd9, 1'b0, '{16'd11, 16'd1, 1'b0, 1'b0, 19, 18});
        @(negedge CLK);
        n_checks++;
        if (div_zero !== 1'b0 || quotient !== 16'd0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL flag_clear_on_accept: got dz=%b q=%h busy=%b, expected dz=0 q=0000 busy=1",
                     div_zero, quotient, busy);
        end else begin
            $display("txn flag_clear_on_accept: dz cleared, q held");
        end
        collect(2, 1, got, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || got !== e) begin
            n_errors++;
            $display("FAIL after_div_zero: got q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d to=%b, expected q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d",
                     got.q, got.r, got.dz, got.ov, got.lat, got.bsy, to, e.q, e.r, e.dz, e.ov, e.lat, e.bsy);
        end else begin
            $display("txn unsigned 100/9: q=%h r=%h lat=%0d", got.q, got.r, got.lat);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] dv[4];
        logic [15:0] ds[4];
        logic        sm[4];
        res_t        ex[4];
        res_t        got;
        res_t        e;
        bit          to;
        dv = '{32'h0001_0000, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_8000};
        ds = '{16'd1, 16'd1, 16'd1, 16'hFFFF};
        sm = '{1'b0, 1'b1, 1'b1, 1'b1};
        ex = '{'{16'h0000, 16'h0000, 1'b0, 1'b1, 2, 1},
               '{16'h0000, 16'h0000, 1'b0, 1'b1, 19, 18},
               '{16'h8000, 16'h0000, 1'b0, 1'b0, 19, 18},
               '{16'h0000, 16'h0000, 1'b0, 1'b1, 19, 18}};
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            issue(dv[i], ds[i], sm[i], ex[i]);
            collect(1, 0, got, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || got !== e) begin
                n_errors++;
                $display("FAIL overflow_%0d: got q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d to=%b, expected q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d",
                         i, got.q, got.r, got.dz, got.ov, got.lat, got.bsy, to, e.q, e.r, e.dz, e.ov, e.lat, e.bsy);
            end else begin
                $display("txn overflow %h/%h sm=%b: q=%h ovf=%b lat=%0d", dv[i], ds[i], sm[i], got.q, got.ov, got.lat);
            end
        end
    endtask

    task automatic test_ignore_start();
        res_t got;
        res_t e;
        bit   to;
        int   lat;
        int   bsy;
        int   extra;
        @(negedge CLK);
        issue(32'd1000, 16'd7, 1'b0, '{16'd142, 16'd6, 1'b0, 1'b0, 19, 18});
        lat = 1;
        bsy = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (busy === 1'b1) bsy++;
            if (k == 5) begin
                start       = 1'b1;
                signed_mode = 1'b1;
                dividend    = 32'd5000;
                divisor     = 16'd3;
            end
            @(posedge CLK);
            lat++;
        end
        #1;
        start = 1'b0;
        collect(lat, bsy, got, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || got !== e) begin
            n_errors++;
            $display("FAIL ignore_start: got q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d to=%b, expected q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d",
                     got.q, got.r, got.dz, got.ov, got.lat, got.bsy, to, e.q, e.r, e.dz, e.ov, e.lat, e.bsy);
        end else begin
            $display("txn ignore_start: original result q=%h r=%h lat=%0d", got.q, got.r, got.lat);
        end
        extra = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge CLK);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_errors++;
            $display("FAIL ignore_start_idle: got %0d busy/done cycles, expected 0", extra);
        end else begin
            $display("txn ignore_start_idle: no second operation");
        end
    endtask

    task automatic test_back_to_back();
        res_t got;
        res_t e;
        bit   to;
        @(negedge CLK);
        issue(32'd1000, 16'd7, 1'b0, '{16'd142, 16'd6, 1'b0, 1'b0, 19, 18});
        for (int i = 0; i < 2; i++) begin
            collect(1, 0, got, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || got !== e) begin
                n_errors++;
                $display("FAIL back_to_back_%0d: got q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d to=%b, expected q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d",
                         i, got.q, got.r, got.dz, got.ov, got.lat, got.bsy, to, e.q, e.r, e.dz, e.ov, e.lat, e.bsy);
            end else begin
                $display("txn back_to_back_%0d: q=%h r=%h lat=%0d", i, got.q, got.r, got.lat);
            end
            // Start asserted in the done cycle itself.
            if (i == 0) issue(32'hFFFF_FC18, 16'd7, 1'b1, '{16'hFF72, 16'hFFFA, 1'b0, 1'b0, 19, 18});
        end
    endtask

    task automatic test_reset_mid();
        res_t got;
        res_t e;
        bit   to;
        int   seen;
        @(negedge CLK);
        issue(32'd60000, 16'd13, 1'b0, '{16'd0, 16'd0, 1'b0, 1'b0, 0, 0});
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b0;
        void'(exp_q.pop_back());
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_zero, ovf} !== 35'd0) begin
            n_errors++;
            $display("FAIL reset_mid_divide: got busy=%b done=%b q=%h r=%h dz=%b ovf=%b, expected all 0",
                     busy, done, quotient, remainder, div_zero, ovf);
        end else begin
            $display("txn reset_mid_divide: outputs cleared immediately");
        end
        @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge CLK);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL reset_no_done: got %0d busy/done cycles, expected 0", seen);
        end else begin
            $display("txn reset_no_done: aborted operation produced nothing");
        end
        issue(32'hFFFF_FC18, 16'hFFF9, 1'b1, '{16'h008E, 16'hFFFA, 1'b0, 1'b0, 19, 18});
        collect(1, 0, got, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || got !== e) begin
            n_errors++;
            $display("FAIL restart_after_reset: got q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d to=%b, expected q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d",
                     got.q, got.r, got.dz, got.ov, got.lat, got.bsy, to, e.q, e.r, e.dz, e.ov, e.lat, e.bsy);
        end else begin
            $display("txn restart_after_reset: q=%h r=%h lat=%0d", got.q, got.r, got.lat);
        end
    endtask

    task automatic test_random();
        res_t        got;
        res_t        e;
        bit          to;
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic        sm;
        longint      dv_s;
        longint      q_s;
        longint      r_s;
        longint      d_s;
        longint      r_abs;
        longint      d_abs;
        @(negedge CLK);
        for (int m = 0; m < 2; m++) begin
            sm = m[0];
            for (int n = 0; n < 800; n++) begin
                dvd = $urandom;
                dvd = dvd >> $urandom_range(0, 31);
                if (sm && $urandom_range(0, 1) == 1) dvd = -dvd;
                dvs = 16'($urandom);
                if ($urandom_range(0, 31) == 0) dvs = 16'd0;
                e = model(dvd, dvs, sm);
                issue(dvd, dvs, sm, e);
                collect(1, 0, got, to);
                e = exp_q.pop_front();
                n_checks++;
                if (to || got !== e) begin
                    n_errors++;
                    $display("FAIL random_%0d_%0d %h/%h: got q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d to=%b, expected q=%h r=%h dz=%b ovf=%b lat=%0d busy=%0d",
                             m, n, dvd, dvs, got.q, got.r, got.dz, got.ov, got.lat, got.bsy, to, e.q, e.r, e.dz, e.ov, e.lat, e.bsy);
                end else begin
                    $display("txn random sm=%b %h/%h: q=%h r=%h dz=%b ovf=%b lat=%0d",
                             sm, dvd, dvs, got.q, got.r, got.dz, got.ov, got.lat);
                end
                if (!to && !got.dz && !got.ov) begin
                    if (sm) begin
                        dv_s = longint'($signed(dvd));
                        q_s  = longint'($signed(got.q));
                        r_s  = longint'($signed(got.r));
                        d_s  = longint'($signed(dvs));
                    end else begin
                        dv_s = longint'(dvd);
                        q_s  = longint'(got.q);
                        r_s  = longint'(got.r);
                        d_s  = longint'(dvs);
                    end
                    r_abs = (r_s < 0) ? -r_s : r_s;
                    d_abs = (d_s < 0) ? -d_s : d_s;
                    n_checks++;
                    if (dv_s != q_s * d_s + r_s || r_abs >= d_abs) begin
                        n_errors++;
                        $display("FAIL invariant_%0d_%0d: got q*d+r=%0d |r|=%0d, expected %0d and |r|<%0d",
                                 m, n, q_s * d_s + r_s, r_abs, dv_s, d_abs);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
